secuenciador_carga: RTL and testbench

Control sequencer for the two-stage capture datapath: a 5-bit value and two 1-bit flags are loaded into first-stage registers, then committed together to second-stage registers. It enforces the capture order T → P → B → commit, emits one-cycle register enables, and supervises each wait with a per-state timeout. It aborts cleanly on an early `terminar` or a timeout, so the second stage never receives a partial set.

---
 rtl/carga_pkg.sv | 23 ++
 rtl/contador_timeout.sv | 40 ++++
 rtl/secuenciador_carga.sv | 167 ++++++++++++++++
 tb/tb_secuenciador_carga.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/carga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carga_pkg
// Description : Shared definitions for the two-stage capture sequencer.
//               State width and state codes (also used by debug logic that
//               decodes the 'estado' output) and the default timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package carga_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_ESP_T = 3'd1;
    localparam logic [ST_W-1:0] ST_ESP_P = 3'd2;
    localparam logic [ST_W-1:0] ST_ESP_B = 3'd3;
    localparam logic [ST_W-1:0] ST_CONF  = 3'd4;
    localparam logic [ST_W-1:0] ST_ERR   = 3'd5;

    localparam int DEF_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/contador_timeout.sv
`default_nettype none
// ============================================================================
// Module      : contador_timeout
// Description : Per-state wait counter for the capture sequencer.
//               Ports: clk, reset (async, active-high), clr (synchronous
//               clear, wins over en), en (count one waiting cycle),
//               fin (count has reached TIMEOUT-1).
//               The count saturates at TIMEOUT-1 and never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_timeout #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic fin
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != c_last)) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign fin = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/secuenciador_carga.sv
`default_nettype none
// ============================================================================
// Module      : secuenciador_carga
// Description : Control sequencer for the two-stage capture datapath.
//               Enforces capture order T -> P -> B -> commit, issuing
//               one-cycle register enables, with a per-state timeout and a
//               clean abort path so the second stage never sees a partial set.
//   Ports:
//     clk, reset                : clock, async active-high reset
//     iniciar                   : start request (accepted in IDLE only)
//     terminar                  : commit in CONF, abort in ESP_T/P/B
//     validat/validap/validab   : stage-valid strobes
//     pasar1/pasar2/pasar3      : first-stage register enables (1 cycle)
//     listo                     : second-stage register enable (1 cycle)
//     ocupado                   : high whenever the state is not IDLE
//     error                     : sticky abort/timeout flag
//     estado                    : current state code (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module secuenciador_carga
    import carga_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iniciar,
    input  logic            terminar,
    input  logic            validat,
    input  logic            validap,
    input  logic            validab,
    output logic            pasar1,
    output logic            pasar2,
    output logic            pasar3,
    output logic            listo,
    output logic            ocupado,
    output logic            error,
    output logic [ST_W-1:0] estado
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next;
    logic            r_pasar1, r_pasar2, r_pasar3, r_listo, r_ocupado, r_error;
    logic            w_pasar1, w_pasar2, w_pasar3, w_listo, w_error;
    logic            w_wait;
    logic            w_en;
    logic            w_fin;

    // The counter only advances while parked in a wait state; any state
    // change (event or timeout) or leaving the wait states clears it.
    assign w_wait = (r_state == ST_ESP_T) || (r_state == ST_ESP_P) ||
                    (r_state == ST_ESP_B) || (r_state == ST_CONF);
    assign w_en   = w_wait && (w_next == r_state);

    contador_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_contador (
        .clk   (clk),
        .reset (reset),
        .clr   (~w_en),
        .en    (w_en),
        .fin   (w_fin)
    );

    // Next state and next registered outputs.
    // Priority inside each wait state: terminar > own valid > timeout.
    always_comb begin
        w_next   = r_state;
        w_pasar1 = 1'b0;
        w_pasar2 = 1'b0;
        w_pasar3 = 1'b0;
        w_listo  = 1'b0;
        w_error  = r_error;
        case (r_state)
            ST_IDLE: begin
                if (iniciar) begin
                    w_next  = ST_ESP_T;
                    w_error = 1'b0;
                end
            end
            ST_ESP_T: begin
                if (terminar) begin
                    w_next  = ST_ERR;
                    w_error = 1'b1;
                end else if (validat) begin
                    w_next   = ST_ESP_P;
                    w_pasar1 = 1'b1;
                end else if (w_fin) begin
                    w_next  = ST_ERR;
                    w_error = 1'b1;
                end
            end
            ST_ESP_P: begin
                if (terminar) begin
                    w_next  = ST_ERR;
                    w_error = 1'b1;
                end else if (validap) begin
                    w_next   = ST_ESP_B;
                    w_pasar2 = 1'b1;
                end else if (w_fin) begin
                    w_next  = ST_ERR;
                    w_error = 1'b1;
                end
            end
            ST_ESP_B: begin
                if (terminar) begin
                    w_next  = ST_ERR;
                    w_error = 1'b1;
                end else if (validab) begin
                    w_next   = ST_CONF;
                    w_pasar3 = 1'b1;
                end else if (w_fin) begin
                    w_next  = ST_ERR;
                    w_error = 1'b1;
                end
            end
            ST_CONF: begin
                if (terminar) begin
                    w_next  = ST_IDLE;
                    w_listo = 1'b1;
                end else if (w_fin) begin
                    w_next  = ST_ERR;
                    w_error = 1'b1;
                end
            end
            ST_ERR: begin
                w_next = ST_IDLE;
            end
            default: begin
                // Codes 6 and 7 are unreachable; fall back to IDLE.
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pasar1  <= 1'b0;
            r_pasar2  <= 1'b0;
            r_pasar3  <= 1'b0;
            r_listo   <= 1'b0;
            r_ocupado <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pasar1  <= w_pasar1;
            r_pasar2  <= w_pasar2;
            r_pasar3  <= w_pasar3;
            r_listo   <= w_listo;
            r_ocupado <= (w_next != ST_IDLE);
            r_error   <= w_error;
        end
    end

    assign pasar1  = r_pasar1;
    assign pasar2  = r_pasar2;
    assign pasar3  = r_pasar3;
    assign listo   = r_listo;
    assign ocupado = r_ocupado;
    assign error   = r_error;
    assign estado  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_carga.sv
`default_nettype none
// ============================================================================
// Module      : tb_secuenciador_carga
// Description : Self-checking bench for secuenciador_carga (TIMEOUT = 4).
//               A phase-level reference model predicts every output each
//               cycle; directed sequences add literal expectations, then a
//               randomized run exercises the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secuenciador_carga;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0, terminar = 1'b0;
    logic       validat = 1'b0, validap = 1'b0, validab = 1'b0;
    logic       pasar1, pasar2, pasar3, listo, ocupado, error;
    logic [2:0] estado;

    int total = 0;
    int bad   = 0;

    secuenciador_carga #(
        .TIMEOUT (TO),
        .CNT_W   (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .iniciar  (iniciar),
        .terminar (terminar),
        .validat  (validat),
        .validap  (validap),
        .validab  (validab),
        .pasar1   (pasar1),
        .pasar2   (pasar2),
        .pasar3   (pasar3),
        .listo    (listo),
        .ocupado  (ocupado),
        .error    (error),
        .estado   (estado)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. phase: 0 idle, 1..3 waiting for capture #phase,
    // 4 waiting for commit, 5 error cycle. 'waited' counts idle cycles in
    // the current phase; after TO-1 of them, one more idle cycle aborts.
    // ------------------------------------------------------------------
    int m_phase  = 0;
    int m_waited = 0;
    bit m_err    = 0;
    bit m_pulse [1:4] = '{0, 0, 0, 0};

    always @(posedge clk or posedge reset) begin
        bit strobe [1:3];
        int prev;
        strobe[1] = validat;
        strobe[2] = validap;
        strobe[3] = validab;
        for (int i = 1; i <= 4; i++) m_pulse[i] = 0;
        if (reset) begin
            m_phase  = 0;
            m_waited = 0;
            m_err    = 0;
        end else begin
            prev = m_phase;
            if (m_phase == 0) begin
                if (iniciar) begin
                    m_phase = 1;
                    m_err   = 0;
                end
            end else if (m_phase == 5) begin
                m_phase = 0;
            end else begin
                if (terminar) begin
                    if (m_phase == 4) begin
                        m_pulse[4] = 1;
                        m_phase    = 0;
                    end else begin
                        m_phase = 5;
                        m_err   = 1;
                    end
                end else if (m_phase <= 3 && strobe[m_phase]) begin
                    m_pulse[m_phase] = 1;
                    m_phase          = m_phase + 1;
                end else if (m_waited == TO - 1) begin
                    m_phase = 5;
                    m_err   = 1;
                end else begin
                    m_waited = m_waited + 1;
                end
            end
            if (m_phase != prev) m_waited = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    bit run_cmp = 0;
    always @(negedge clk) begin
        if (run_cmp) begin
            check("model pasar1",  int'(pasar1),  int'(m_pulse[1]));
            check("model pasar2",  int'(pasar2),  int'(m_pulse[2]));
            check("model pasar3",  int'(pasar3),  int'(m_pulse[3]));
            check("model listo",   int'(listo),   int'(m_pulse[4]));
            check("model ocupado", int'(ocupado), int'(m_phase != 0));
            check("model error",   int'(error),   int'(m_err));
            check("model estado",  int'(estado),  m_phase);
        end
    end

    // Apply one cycle of inputs; returns just after the following negedge,
    // so the outputs reflect the edge that sampled these inputs.
    task automatic drive(input bit ini, input bit vt, input bit vp, input bit vb, input bit te);
        iniciar  = ini;
        validat  = vt;
        validap  = vp;
        validab  = vb;
        terminar = te;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        #1;
        // Reset state
        check("rst estado", int'(estado), 0);
        check("rst ocupado", int'(ocupado), 0);
        check("rst error", int'(error), 0);
        check("rst enables", int'({pasar1, pasar2, pasar3, listo}), 0);
        reset = 1'b0;
        run_cmp = 1;
        idle(1);

        // Nominal fastest sequence
        drive(1, 0, 0, 0, 0);
        check("nom estado T", int'(estado), 1);
        check("nom ocupado", int'(ocupado), 1);
        drive(0, 1, 0, 0, 0);
        check("nom pasar1", int'({pasar1, pasar2, pasar3, listo}), 8);
        drive(0, 0, 1, 0, 0);
        check("nom pasar2", int'({pasar1, pasar2, pasar3, listo}), 4);
        drive(0, 0, 0, 1, 0);
        check("nom pasar3", int'({pasar1, pasar2, pasar3, listo}), 2);
        drive(0, 0, 0, 0, 1);
        check("nom listo", int'({pasar1, pasar2, pasar3, listo}), 1);
        check("nom estado idle", int'(estado), 0);
        idle(1);
        check("nom no pulse", int'({pasar1, pasar2, pasar3, listo}), 0);
        check("nom ocupado low", int'(ocupado), 0);
        check("nom error", int'(error), 0);

        // Out-of-order strobes in ESP_T, then validat on the last allowed cycle
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 0);
            check("ooo estado", int'(estado), 1);
            check("ooo pulses", int'({pasar1, pasar2, pasar3, listo}), 0);
        end
        drive(0, 1, 0, 0, 0);
        check("ooo pasar1", int'(pasar1), 1);
        check("ooo no error", int'(error), 0);

        // Early abort in ESP_P
        drive(0, 0, 0, 0, 1);
        check("abort estado", int'(estado), 5);
        check("abort error", int'(error), 1);
        check("abort pulses", int'({pasar1, pasar2, pasar3, listo}), 0);
        idle(1);
        check("abort back idle", int'(estado), 0);
        check("abort error held", int'(error), 1);
        check("abort ocupado", int'(ocupado), 0);
        drive(1, 0, 0, 0, 0);
        check("abort error cleared", int'(error), 0);

        // Timeout in ESP_B
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        idle(3);
        check("tmo still waiting", int'(estado), 3);
        check("tmo no error yet", int'(error), 0);
        idle(1);
        check("tmo error", int'(error), 1);
        check("tmo estado err", int'(estado), 5);
        check("tmo ocupado", int'(ocupado), 1);
        idle(1);
        check("tmo ocupado low", int'(ocupado), 0);

        // validab on the 4th waiting cycle, terminar on the last CONF cycle
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        idle(3);
        drive(0, 0, 0, 1, 0);
        check("late pasar3", int'(pasar3), 1);
        check("late error", int'(error), 0);
        idle(3);
        drive(0, 0, 0, 0, 1);
        check("late listo", int'(listo), 1);
        check("late error2", int'(error), 0);

        // validat together with terminar in ESP_T
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        check("simul estado", int'(estado), 5);
        check("simul pasar1", int'(pasar1), 0);
        check("simul error", int'(error), 1);
        idle(1);

        // Reset in ESP_B, right after pasar2 has been issued
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        iniciar = 0; validat = 0; validap = 1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rstmid outputs", int'({pasar1, pasar2, pasar3, listo, ocupado, error}), 0);
        check("rstmid estado", int'(estado), 0);
        @(negedge clk);
        #1;
        idle(1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1, 0);
            check("rstmid no pulses", int'({pasar1, pasar2, pasar3, listo}), 0);
        end
        drive(0, 0, 0, 0, 1);
        check("rstmid idle", int'(estado), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            else reset = 1'b0;
            drive(bit'($urandom_range(0, 3) == 0),
                  bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 9) == 0));
        end
        reset = 1'b0;
        idle(2);

        run_cmp = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
